// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with load, saturate/wrap and cascade carry.
// Optional sticky overflow flag when BCD_CNT_OVF_STICKY_EN is defined.
module bcd_counter_n #(
  parameter int DIGITS = 2,
  parameter int SAT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_CNT_OVF_STICKY_EN
  input  logic                  ovf_clr,
  output logic                  ovf,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry
);

  localparam int  W    = 4 * DIGITS;
  localparam bit  HOLD = (SAT != 0);

  logic [W-1:0] nxt;
  logic [W-1:0] lv;
  logic         term;
  logic         chain;
  logic [3:0]   d;

  // Out-of-range digits step to the wrap value for the direction.
  function automatic logic [3:0] step(
    input logic [3:0] v,
    input logic       dir
  );
    logic [3:0] r;
    unique case (1'b1)
      (dir & (v >= 4'd9)):               r = 4'd0;
      (dir & (v <  4'd9)):               r = v + 4'd1;
      (~dir & ((v == 4'd0) | (v > 4'd9))): r = 4'd9;
      default:                           r = v - 4'd1;
    endcase
    return r;
  endfunction

  always_comb begin
    nxt   = count;
    chain = 1'b1;
    d     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (chain) nxt[4*i +: 4] = step(d, up);
      chain = chain & (up ? (d == 4'd9) : (d == 4'd0));
    end
    term = chain;
  end

  always_comb begin
    lv = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) lv[4*i +: 4] = 4'd9;
    end
  end

  assign carry = x & ~load & term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= lv;
    end else if (x && !(HOLD && term)) begin
      count <= nxt;
    end
  end

`ifdef BCD_CNT_OVF_STICKY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (carry) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: wrap (SAT=0) and hold (SAT=1) instances.
module tb_bcd_counter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] cnt0, cnt1;
  logic       cy0, cy1;
`ifdef BCD_CNT_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf0, ovf1;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .SAT(0)) d0 (
    .clk(clk), .reset(reset), .x(x), .up(up),
    .load(load), .load_val(load_val),
`ifdef BCD_CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf0),
`endif
    .count(cnt0), .carry(cy0)
  );

  bcd_counter_n #(.DIGITS(2), .SAT(1)) d1 (
    .clk(clk), .reset(reset), .x(x), .up(up),
    .load(load), .load_val(load_val),
`ifdef BCD_CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf1),
`endif
    .count(cnt1), .carry(cy1)
  );

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; up = 1'b1;
    load = 1'b0; load_val = 8'h00;
`ifdef BCD_CNT_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    #2;
    check("reset_cnt0", 32'(cnt0), 32'h00);
    check("reset_cnt1", 32'(cnt1), 32'h00);
    check("reset_carry_up", 32'(cy0), 32'h0);
    x = 1'b1; up = 1'b0; #1;
    check("reset_carry_dn", 32'(cy0), 32'h1);
    x = 1'b0; up = 1'b1;
`ifdef BCD_CNT_OVF_STICKY_EN
    check("reset_ovf", 32'(ovf0), 32'h0);
`endif
    tick();
    reset = 1'b0;
    tick();
    check("held_zero", 32'(cnt0), 32'h00);

    // 1: count up through a full wrap
    x = 1'b1; up = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      check("up_cnt", 32'(cnt0), 32'(bcd(n)));
      check("up_carry", 32'(cy0), 32'(n == 99));
      tick();
      n = (n + 1) % 100;
    end
    check("up_wrap", 32'(cnt0), 32'h00);

    // 2: clamped load then count down across 00
    load = 1'b1; load_val = 8'h4C;
    tick();
    check("load_clamp0", 32'(cnt0), 32'h49);
    check("load_clamp1", 32'(cnt1), 32'h49);
    load = 1'b0; up = 1'b0; x = 1'b1;
    n = 49;
    for (int i = 0; i < 50; i++) begin
      #1;
      check("dn_cnt", 32'(cnt0), 32'(bcd(n)));
      check("dn_carry", 32'(cy0), 32'(n == 0));
      tick();
      n = (n == 0) ? 99 : n - 1;
    end
    check("dn_wrap0", 32'(cnt0), 32'h99);
    check("dn_hold1", 32'(cnt1), 32'h00);
    check("dn_carry1", 32'(cy1), 32'h1);

    // 3: saturate up and down
    x = 1'b0; load = 1'b1; load_val = 8'h98;
    tick();
    load = 1'b0; x = 1'b1; up = 1'b1;
    tick();
    check("sat_up1", 32'(cnt1), 32'h99);
    check("sat_cy1", 32'(cy1), 32'h1);
    check("wrap_a", 32'(cnt0), 32'h99);
    tick();
    check("sat_up2", 32'(cnt1), 32'h99);
    check("wrap_b", 32'(cnt0), 32'h00);
    tick();
    check("sat_up3", 32'(cnt1), 32'h99);
    check("sat_cy3", 32'(cy1), 32'h1);
    check("wrap_c", 32'(cnt0), 32'h01);
    x = 1'b0; load = 1'b1; load_val = 8'h01;
    tick();
    load = 1'b0; x = 1'b1; up = 1'b0;
    tick();
    check("sat_dn1", 32'(cnt1), 32'h00);
    tick();
    check("sat_dn2", 32'(cnt1), 32'h00);
    check("dn_b0", 32'(cnt0), 32'h99);
    tick();
    check("sat_dn3", 32'(cnt1), 32'h00);
    check("dn_c0", 32'(cnt0), 32'h98);

    // 4: load masks carry and beats the step
    load = 1'b1; load_val = 8'h37; #1;
    check("load_no_carry", 32'(cy1), 32'h0);
    up = 1'b1;
    tick();
    check("load_over_step", 32'(cnt0), 32'h37);

    // 5: asynchronous reset mid-cycle
    load_val = 8'h56;
    tick();
    load = 1'b0;
    tick();
    check("pre_reset", 32'(cnt0), 32'h57);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("async_clr0", 32'(cnt0), 32'h00);
    check("async_clr1", 32'(cnt1), 32'h00);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset", 32'(cnt0), 32'h01);

`ifdef BCD_CNT_OVF_STICKY_EN
    // 6: sticky overflow
    x = 1'b0; ovf_clr = 1'b1; load = 1'b1; load_val = 8'h98;
    tick();
    check("ovf_cleared", 32'(ovf0), 32'h0);
    ovf_clr = 1'b0; load = 1'b0; x = 1'b1; up = 1'b1;
    tick();
    check("ovf_at99", 32'(ovf0), 32'h0);
    tick();
    check("ovf_wrap_cnt", 32'(cnt0), 32'h00);
    check("ovf_set", 32'(ovf0), 32'h1);
    x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovf_held", 32'(ovf0), 32'h1);
    end
    ovf_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(ovf0), 32'h0);
    ovf_clr = 1'b0; load = 1'b1; load_val = 8'h99;
    tick();
    load = 1'b0; x = 1'b1; ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", 32'(ovf0), 32'h1);
    check("ovf_hold1", 32'(ovf1), 32'h1);
    ovf_clr = 1'b0; x = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
